// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  // Architectural register indices with fixed meaning in the MIPS ABI.
  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  typedef logic [DEF_AW-1:0]   reg_idx_t;
  typedef logic [DEF_XLEN-1:0] word_t;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: register select, same-cycle write bypass, busy qualification.
// Latency: combinational, zero cycles.
// Backpressure: none; always presents a value for the addressed register.
// Ports: reset (bypass suppressed while high), wr_en/wr_num/wr_data (both write
// ports, for bypass), regs_flat/busy_vec (stored state, slot 0 ignored),
// rd_num -> rd_data, rd_busy.
import regfile_pkg::*;

module regfile_rdport #(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                  reset,
  input  logic [1:0]            wr_en,
  input  logic [2*AW-1:0]       wr_num,
  input  logic [2*XLEN-1:0]     wr_data,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [NREGS-1:0]      busy_vec,
  input  logic [AW-1:0]         rd_num,
  output logic [XLEN-1:0]       rd_data,
  output logic                  rd_busy
);

  logic hit0, hit1;

  // While reset is high no write can land, so nothing may be forwarded.
  assign hit0 = !reset && wr_en[0] && (wr_num[AW-1:0]  == rd_num);
  assign hit1 = !reset && wr_en[1] && (wr_num[2*AW-1:AW] == rd_num);

  always_comb begin
    rd_data = regs_flat[rd_num*XLEN +: XLEN];
    rd_busy = busy_vec[rd_num];
    // Port1 (load path) has priority, matching what the storage will keep.
    if (hit1) begin
      rd_data = wr_data[XLEN +: XLEN];
      rd_busy = 1'b0;
    end else if (hit0) begin
      rd_data = wr_data[0 +: XLEN];
      rd_busy = 1'b0;
    end
    if (rd_num == AW'(REG_ZERO)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: 2 write ports, NRD read ports with bypass, busy scoreboard.
// Latency: reads combinational; writes and busy updates land at the next rising edge.
// Backpressure: none; the hazard unit stalls on rd_busy/any_busy externally.
// Ports: clk, reset (async, active-high), wr_en/wr_num/wr_data (port0 ALU,
// port1 load), rd_num -> rd_data/rd_busy, alloc_en/alloc_num (issue), any_busy.
import regfile_pkg::*;

module regfile_mp #(
  parameter int              XLEN    = DEF_XLEN,
  parameter int              NREGS   = DEF_NREGS,
  parameter int              AW      = $clog2(NREGS),
  parameter int              NRD     = 2,
  parameter int              SP_IDX  = REG_SP,
  parameter logic [XLEN-1:0] SP_INIT = '0,
  parameter int              RA_IDX  = REG_RA,
  parameter logic [XLEN-1:0] RA_INIT = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_num,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic [NRD*AW-1:0]   rd_num,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_num,
  output logic                any_busy
);

  logic [XLEN-1:0]       regs [1:NREGS-1];
  logic [NREGS-1:1]      busy_q;
  logic [NREGS*XLEN-1:0] regs_flat;
  logic [NREGS-1:0]      busy_vec;
  logic [AW-1:0]         wnum0, wnum1;

  assign wnum0 = wr_num[0 +: AW];
  assign wnum1 = wr_num[AW +: AW];

  // Register storage. Port1 is tested first so it wins a same-index collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        if (i == SP_IDX)      regs[i] <= SP_INIT;
        else if (i == RA_IDX) regs[i] <= RA_INIT;
        else                  regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_en[1] && wnum1 == AW'(i))      regs[i] <= wr_data[XLEN +: XLEN];
        else if (wr_en[0] && wnum0 == AW'(i)) regs[i] <= wr_data[0 +: XLEN];
      end
    end
  end

  // Busy scoreboard: writeback clears, then issue sets, so a same-cycle
  // alloc of a register being written back leaves it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (alloc_en && alloc_num == AW'(i))
          busy_q[i] <= 1'b1;
        else if ((wr_en[0] && wnum0 == AW'(i)) || (wr_en[1] && wnum1 == AW'(i)))
          busy_q[i] <= 1'b0;
      end
    end
  end

  assign any_busy = |busy_q;
  assign busy_vec = {busy_q, 1'b0};

  assign regs_flat[0 +: XLEN] = '0;
  for (genvar g = 1; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*XLEN +: XLEN] = regs[g];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_num    (wr_num),
      .wr_data   (wr_data),
      .regs_flat (regs_flat),
      .busy_vec  (busy_vec),
      .rd_num    (rd_num[k*AW +: AW]),
      .rd_data   (rd_data[k*XLEN +: XLEN]),
      .rd_busy   (rd_busy[k])
    );
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS core, replacing the single-write/two-read file.
- Configurable data width, register count and read-port count.
- Two write ports with deterministic priority, and same-cycle write-to-read bypass so decode sees writeback data without a half-cycle trick.
- Per-register busy scoreboard: set at issue, cleared at writeback; the hazard unit reads it for stall decisions.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=4); register 0 reads as zero
AW, $clog2(NREGS), register index width (derived, not overridden)
NRD, 2, number of read ports (1..4)
SP_IDX, 29, index of stack pointer register
SP_INIT, 0, stack pointer value at reset
RA_IDX, 31, index of return-address register
RA_INIT, 0, return-address value at reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, asynchronous, active-high
wr_en  in  2  write enable per write port (bit0 = port0 = ALU path, bit1 = port1 = load path)
wr_num  in  2*AW  write register index per port, port p at [p*AW +: AW]
wr_data  in  2*XLEN  write data per port, port p at [p*XLEN +: XLEN]
rd_num  in  NRD*AW  read register index per port
rd_data  out  NRD*XLEN  read data per port (combinational)
rd_busy  out  NRD  busy flag of the addressed register (combinational)
alloc_en  in  1  mark a destination register busy (instruction issue)
alloc_num  in  AW  register index to mark busy
any_busy  out  1  OR of all busy bits (drain/flush indicator)

Behaviour:
- Storage: NREGS-1 registers of XLEN (index 0 not stored), plus NREGS-1 busy flops.
- Reset (asynchronous, takes effect immediately): reg[SP_IDX]=SP_INIT, reg[RA_IDX]=RA_INIT, all other registers 0, all busy bits 0. Outputs during reset: rd_data shows the reset values, rd_busy=0, any_busy=0.
- Write, at posedge: wr_en[p] && wr_num[p]!=0 writes reg[wr_num[p]] = wr_data[p].
  - Both ports targeting the same nonzero register: port1 data is stored.
  - Any write to index 0 is ignored.
- Read, combinational, zero latency:
  - rd_num==0 gives 0.
  - Otherwise, if an enabled write port in the same cycle targets rd_num, forward that port's wr_data (port1 over port0).
  - Otherwise return the stored value.
- Busy update at posedge, per nonzero index i, in this order:
  - cleared if any enabled write port targets i;
  - then set if alloc_en && alloc_num==i, so alloc wins over same-cycle clear.
  - alloc_num==0 is ignored.
  - Busy is never set by anything other than alloc.
- rd_busy[k] = busy[rd_num[k]] AND NOT (same-cycle enabled write to rd_num[k]), so the value is consistent with the bypass. A same-cycle alloc does not affect rd_busy until the next cycle. rd_busy for index 0 is always 0.
- Alloc on an already-busy register: it stays busy with no error, and a single writeback clears it. The hazard unit must stall a WAW alloc.
- Reset asserted mid-operation: all busy bits drop immediately and pending writes are lost. Writes resume on the first posedge after deassertion.
- No X propagation: out-of-range indices cannot occur (NREGS is a power of 2).

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/NREGS;
  - localparams REG_ZERO=0, REG_SP=29, REG_RA=31;
  - typedef reg_idx_t (logic [AW-1:0]);
  - typedef word_t (logic [XLEN-1:0]).
- One sub-module, regfile_rdport: combinational read mux plus bypass plus busy qualification for a single port, instantiated NRD times via generate.
- Storage and scoreboard stay in regfile_mp.

Test Plan:
1. Reset with SP_INIT=32'h7FFF_EFFC, RA_INIT=32'h0040_0000 -> rd_num=29 reads 7FFFEFFC, rd_num=31 reads 00400000, rd_num=5 reads 0, any_busy=0.
2. wr_en=01, wr_num0=8, wr_data0=32'hDEAD_BEEF with rd_num0=8 in the same cycle -> rd_data0=DEADBEEF combinationally; next cycle with wr_en=0 still reads DEADBEEF.
3. Both ports write reg 9: port0 32'h1111_1111, port1 32'h2222_2222 -> same-cycle read and stored value are 22222222. A write to reg 0 of 32'hFFFF_FFFF still reads 0.
4. alloc_en=1, alloc_num=10, then the next cycle rd_num1=10 -> rd_busy1=1, any_busy=1. Writeback to reg 10 with 32'h5 -> rd_busy1=0 in that cycle; after the edge, busy cleared and any_busy=0.
5. alloc to reg 12 and write to reg 12 in the same cycle -> after the edge rd_busy=1 (alloc wins).
6. Assert reset asynchronously between edges while reg 12 is busy and reg 8 holds DEADBEEF -> busy and any_busy drop immediately, reg 8 reads 0. After deassertion, the first write succeeds.
